// File: rtl/ebus_responder.sv
// ============================================================================
// Module      : ebus_responder
// Description : KL10 EBUS device-side responder (CONO/CONI/DATAO/DATAI).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ebus_responder #(
  parameter logic [6:0] DEVICE_CS = 7'o20
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic [0:6]  ebusCS,
  input  logic [0:2]  ebusFunc,
  input  logic        ebusDemand,
  input  logic [0:35] ebusData,
  output logic        ebusXfer,
  output logic        driving,
  output logic [0:35] drvData,
  output logic [1:7]  ebusPI,
  input  logic [18:23] status,
  input  logic        doneSet,
  output logic        dataoValid,
  output logic [0:35] dataoData,
  input  logic        dataoReady,
  input  logic        dataiValid,
  input  logic [0:35] dataiData,
  output logic        dataiTake,
  output logic [24:35] conReg,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DOUT  = 3'd1;
  localparam logic [2:0] S_DIN   = 3'd2;
  localparam logic [2:0] S_DRIVE = 3'd3;
  localparam logic [2:0] S_XFER  = 3'd4;

  localparam logic [2:0] C_F_CONO  = 3'd0;
  localparam logic [2:0] C_F_CONI  = 3'd1;
  localparam logic [2:0] C_F_DATAO = 3'd2;
  localparam logic [2:0] C_F_DATAI = 3'd3;

  logic [2:0]  state_q, state_d;
  logic        drv_sel_q, drv_sel_d;
  logic [35:0] drv_data_q, drv_data_d;
  logic [35:0] datao_q, datao_d;
  logic [11:0] conreg_q, conreg_d;
  logic        done_q, done_d;
  logic [6:0]  pi_q, pi_d;
  logic        cono_clr;
  logic        w_start;
  logic [2:0]  w_func;

  // CONI reads the done flag in place of live status bit 23.
  logic unused_status;
  assign unused_status = status[23];

  assign w_func  = ebusFunc;
  assign w_start = ebusDemand && (ebusCS == DEVICE_CS) && (w_func <= C_F_DATAI);

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state_q    <= S_IDLE;
      drv_sel_q  <= 1'b0;
      drv_data_q <= '0;
      datao_q    <= '0;
      conreg_q   <= '0;
      done_q     <= 1'b0;
      pi_q       <= '0;
    end else begin
      state_q    <= state_d;
      drv_sel_q  <= drv_sel_d;
      drv_data_q <= drv_data_d;
      datao_q    <= datao_d;
      conreg_q   <= conreg_d;
      done_q     <= done_d;
      pi_q       <= pi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drv_sel_d  = drv_sel_q;
    drv_data_d = drv_data_q;
    datao_d    = datao_q;
    conreg_d   = conreg_q;
    cono_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          case (w_func)
            C_F_CONO: begin
              conreg_d  = ebusData[24:35];
              cono_clr  = ebusData[23];
              drv_sel_d = 1'b0;
              state_d   = S_XFER;
            end
            C_F_CONI: begin
              drv_data_d = {18'b0, status[18:22], done_q, conreg_q};
              drv_sel_d  = 1'b1;
              state_d    = S_DRIVE;
            end
            C_F_DATAO: begin
              datao_d   = ebusData;
              drv_sel_d = 1'b0;
              state_d   = S_DOUT;
            end
            default: begin
              drv_sel_d = 1'b1;
              state_d   = S_DIN;
            end
          endcase
        end
      end
      S_DOUT: begin
        if (!ebusDemand)     state_d = S_IDLE;
        else if (dataoReady) state_d = S_XFER;
      end
      S_DIN: begin
        if (!ebusDemand) begin
          state_d = S_IDLE;
        end else if (dataiValid) begin
          drv_data_d = dataiData;
          state_d    = S_DRIVE;
        end
      end
      S_DRIVE: state_d = ebusDemand ? S_XFER : S_IDLE;
      S_XFER:  if (!ebusDemand) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Set wins over a simultaneous CONO clear.
    done_d = done_q;
    if (cono_clr) done_d = 1'b0;
    if (doneSet)  done_d = 1'b1;

    pi_d = '0;
    for (int p = 1; p <= 7; p++) begin
      pi_d[7-p] = done_q && (conreg_q[2:0] == 3'(p));
    end
  end

  always_comb begin
    ebusXfer   = (state_q == S_XFER);
    driving    = (state_q == S_DRIVE) || ((state_q == S_XFER) && drv_sel_q);
    drvData    = driving ? drv_data_q : '0;
    dataoValid = (state_q == S_DOUT);
    dataoData  = datao_q;
    dataiTake  = (state_q == S_DIN) && ebusDemand && dataiValid;
    conReg     = conreg_q;
    done       = done_q;
    ebusPI     = pi_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ebus_responder.sv
// ============================================================================
// Module      : tb_ebus_responder
// Description : Scoreboard bench for ebus_responder with a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ebus_responder;

  localparam logic [6:0] CS = 7'o20;

  logic        clk = 1'b0;
  logic        CROBAR;
  logic [0:6]  ebusCS;
  logic [0:2]  ebusFunc;
  logic        ebusDemand;
  logic [0:35] ebusData;
  logic        ebusXfer;
  logic        driving;
  logic [0:35] drvData;
  logic [1:7]  ebusPI;
  logic [18:23] status;
  logic        doneSet;
  logic        dataoValid;
  logic [0:35] dataoData;
  logic        dataoReady;
  logic        dataiValid;
  logic [0:35] dataiData;
  logic        dataiTake;
  logic [24:35] conReg;
  logic        done;

  ebus_responder #(.DEVICE_CS(CS)) dut (
    .clk(clk), .CROBAR(CROBAR), .ebusCS(ebusCS), .ebusFunc(ebusFunc),
    .ebusDemand(ebusDemand), .ebusData(ebusData), .ebusXfer(ebusXfer),
    .driving(driving), .drvData(drvData), .ebusPI(ebusPI), .status(status),
    .doneSet(doneSet), .dataoValid(dataoValid), .dataoData(dataoData),
    .dataoReady(dataoReady), .dataiValid(dataiValid), .dataiData(dataiData),
    .dataiTake(dataiTake), .conReg(conReg), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'o%0o, expected 'o%0o", name, act, exp);
  endtask

  // Reference model: device registers as plain values.
  logic [11:0] m_conreg = '0;
  bit          m_done   = 1'b0;

  function automatic logic [6:0] exp_pi();
    int pia;
    pia = int'(m_conreg[2:0]);
    if (!m_done || pia == 0) return 7'd0;
    return 7'(1 << (7 - pia));
  endfunction

  typedef struct {
    bit          drv;
    logic [35:0] data;
    int          lat;
  } xf_t;

  xf_t         xq[$];
  logic [35:0] dq[$];

  // Monitor: compares DUT responses against queued expectations.
  int cyc = 0;
  bit dem_p = 1'b0;
  bit xf_p = 1'b0;
  int take_cnt = 0;
  int drv_cnt = 0;

  always @(negedge clk) begin
    xf_t e;
    if (ebusDemand && !dem_p) cyc = 0;
    else cyc++;
    dem_p = ebusDemand;
    if (dataiTake) take_cnt++;
    if (driving) drv_cnt++;
    if (ebusXfer && !xf_p) begin
      if (xq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_xfer: got xfer=1, expected no transfer");
      end else begin
        e = xq.pop_front();
        check("xfer_latency", 64'(cyc), 64'(e.lat));
        check("xfer_driving", 64'(driving), 64'(e.drv));
        check("xfer_data", 64'(drvData), e.drv ? 64'(e.data) : 64'd0);
      end
    end
    xf_p = ebusXfer;
    if (dataoValid && dataoReady) begin
      if (dq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_datao: got word 'o%0o, expected none", dataoData);
      end else begin
        check("datao_word", 64'(dataoData), 64'(dq.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    doneSet = 1'b1;
    tick();
    doneSet = 1'b0;
    m_done  = 1'b1;
  endtask

  task automatic do_txn(input int func, input logic [6:0] cs, input logic [35:0] data,
                        input int dly, input bit set_at0);
    bit  match;
    int  d0, t0, k;
    xf_t e;
    match = (cs == CS) && (func <= 3);
    d0 = drv_cnt;
    t0 = take_cnt;
    ebusCS     = cs;
    ebusFunc   = 3'(func);
    ebusData   = data;
    dataiData  = data;
    dataoReady = (dly == 0);
    dataiValid = (dly == 0);
    if (match) begin
      e.drv  = (func == 1) || (func == 3);
      e.data = '0;
      e.lat  = 0;
      case (func)
        0: begin
          e.lat    = 1;
          m_conreg = data[11:0];
          if (data[12]) m_done = 1'b0;
        end
        1: begin
          e.lat  = 2;
          e.data = {18'b0, status[18:22], m_done, m_conreg};
        end
        2: begin
          e.lat = 2 + dly;
          dq.push_back(data);
        end
        default: begin
          e.lat  = 3 + dly;
          e.data = data;
        end
      endcase
      xq.push_back(e);
    end
    if (set_at0) m_done = 1'b1;
    ebusDemand = 1'b1;
    doneSet    = set_at0;
    tick();
    doneSet = 1'b0;
    repeat (dly) tick();
    dataoReady = 1'b1;
    dataiValid = 1'b1;
    if (match) begin
      k = 0;
      while (!ebusXfer && k < 50) begin
        tick();
        k++;
      end
      if (!ebusXfer) begin
        n_checks++;
        $display("FAIL xfer_timeout: got no xfer in 50 cycles, expected xfer (func %0d)", func);
      end
      tick();
      check("xfer_hold", 64'(ebusXfer), 64'd1);
    end else begin
      repeat (6) tick();
    end
    ebusDemand = 1'b0;
    dataoReady = 1'b0;
    dataiValid = 1'b0;
    tick();
    check("release_xfer", 64'(ebusXfer), 64'd0);
    check("release_driving", 64'(driving), 64'd0);
    if (!match || func == 0 || func == 2) check("no_drive", 64'(drv_cnt - d0), 64'd0);
    check("take_count", 64'(take_cnt - t0), (match && func == 3) ? 64'd1 : 64'd0);
    check("conreg", 64'(conReg), 64'(m_conreg));
    check("done", 64'(done), 64'(m_done));
    check("pi", 64'(ebusPI), 64'(exp_pi()));
  endtask

  task automatic abort_din();
    int d0, t0;
    d0 = drv_cnt;
    t0 = take_cnt;
    ebusCS     = CS;
    ebusFunc   = 3'd3;
    dataiValid = 1'b0;
    ebusDemand = 1'b1;
    repeat (3) tick();
    ebusDemand = 1'b0;
    repeat (2) tick();
    dataiValid = 1'b1;
    tick();
    dataiValid = 1'b0;
    check("abort_take", 64'(take_cnt - t0), 64'd0);
    check("abort_drive", 64'(drv_cnt - d0), 64'd0);
    check("abort_xfer", 64'(ebusXfer), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          f, dly;
    logic [6:0]  cs;
    logic [35:0] d;
    CROBAR = 1'b1; ebusCS = '0; ebusFunc = '0; ebusDemand = 1'b0; ebusData = '0;
    status = '0; doneSet = 1'b0; dataoReady = 1'b0; dataiValid = 1'b0; dataiData = '0;
    repeat (2) tick();
    check("rst_xfer", 64'(ebusXfer), 64'd0);
    check("rst_driving", 64'(driving), 64'd0);
    check("rst_conreg", 64'(conReg), 64'd0);
    check("rst_pi", 64'(ebusPI), 64'd0);
    check("rst_datao", 64'({dataoValid, dataoData}), 64'd0);
    CROBAR = 1'b0;
    tick();

    // Populate state, then reset in the middle of a CONI drive phase.
    do_txn(0, CS, 36'o000000_000145, 0, 0);
    pulse_done();
    status     = 6'o52;
    ebusCS     = CS;
    ebusFunc   = 3'd1;
    ebusDemand = 1'b1;
    tick();
    check("pre_reset_drive", 64'(driving), 64'd1);
    CROBAR = 1'b1;
    #1;
    check("reset_driving", 64'(driving), 64'd0);
    check("reset_xfer", 64'(ebusXfer), 64'd0);
    check("reset_drvdata", 64'(drvData), 64'd0);
    ebusDemand = 1'b0;
    tick();
    CROBAR = 1'b0;
    tick();
    m_conreg = '0;
    m_done   = 1'b0;
    check("post_reset_conreg", 64'(conReg), 64'd0);
    check("post_reset_done", 64'(done), 64'd0);

    do_txn(0, CS, 36'o000000_010123, 0, 0);
    check("cono_value", 64'(conReg), 64'o0123);
    doneSet = 1'b1;
    tick();
    doneSet = 1'b0;
    m_done  = 1'b1;
    check("pi_lag", 64'(ebusPI), 64'd0);
    tick();
    check("pi_line3", 64'(ebusPI), 64'b0010000);
    do_txn(0, CS, 36'o000000_010123, 0, 0);
    status = 6'o52;
    do_txn(1, CS, 36'd0, 0, 0);
    do_txn(2, CS, 36'o123456_701234, 5, 0);
    do_txn(3, CS, 36'o777000_000777, 3, 0);
    abort_din();
    do_txn(3, CS, 36'o000111_222333, 0, 0);
    do_txn(0, CS ^ 7'd1, 36'o000000_000007, 0, 0);
    do_txn(4, CS, 36'o000000_000007, 0, 0);
    do_txn(0, CS, 36'o000000_010077, 0, 1);

    for (int i = 0; i < 60; i++) begin
      f = int'($urandom_range(0, 4));
      if (f == 4) f = int'($urandom_range(4, 7));
      cs = CS;
      if ($urandom_range(0, 7) == 0) cs = CS ^ 7'(1 << $urandom_range(0, 6));
      d = {4'($urandom()), 32'($urandom())};
      dly = int'($urandom_range(0, 4));
      status = 6'($urandom());
      if ($urandom_range(0, 2) == 0) pulse_done();
      do_txn(f, cs, d, dly, (f == 0) && ($urandom_range(0, 3) == 0));
    end

    repeat (3) tick();
    check("scoreboard_drained", 64'(xq.size() + dq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
